// File: rtl/user_obi_copy_engine.sv
// user_obi_copy_engine: OBI register-programmed word copy engine.
// Copies LEN 32-bit words from SRC to DST through a single OBI manager port,
// keeping at most one transaction outstanding. Completion raises a level irq.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   sbr_obi_req_i   register-port request  (gnt is combinational, never stalls)
//   sbr_obi_rsp_o   register-port response (rvalid one cycle after grant)
//   mgr_obi_req_o   copy-traffic request (registered)
//   mgr_obi_rsp_i   copy-traffic response
//   irq_o           DONE & IRQ_EN
package user_obi_copy_engine_pkg;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiIdWidth   = 4;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t DefaultSbrObiCfg = '{AddrWidth: ObiAddrWidth,
                                            DataWidth: ObiDataWidth,
                                            IdWidth:   ObiIdWidth};
  localparam obi_cfg_t DefaultMgrObiCfg = '{AddrWidth: ObiAddrWidth,
                                            DataWidth: ObiDataWidth,
                                            IdWidth:   ObiIdWidth};

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [ObiDataWidth/8-1:0] be;
    logic [ObiDataWidth-1:0]   wdata;
    logic [ObiIdWidth-1:0]     aid;
  } obi_a_t;

  typedef struct packed {
    logic   req;
    obi_a_t a;
  } obi_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic [ObiIdWidth-1:0]   rid;
    logic                    err;
  } obi_r_t;

  typedef struct packed {
    logic   gnt;
    logic   rvalid;
    obi_r_t r;
  } obi_rsp_t;

endpackage

module user_obi_copy_engine
  import user_obi_copy_engine_pkg::*;
#(
  parameter obi_cfg_t    SbrObiCfg     = DefaultSbrObiCfg,
  parameter obi_cfg_t    MgrObiCfg     = DefaultMgrObiCfg,
  parameter type         sbr_obi_req_t = obi_req_t,
  parameter type         sbr_obi_rsp_t = obi_rsp_t,
  parameter type         mgr_obi_req_t = obi_req_t,
  parameter type         mgr_obi_rsp_t = obi_rsp_t,
  parameter int unsigned LenWidth      = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  sbr_obi_req_t sbr_obi_req_i,
  output sbr_obi_rsp_t sbr_obi_rsp_o,
  output mgr_obi_req_t mgr_obi_req_o,
  input  mgr_obi_rsp_t mgr_obi_rsp_i,
  output logic         irq_o
);

  localparam int unsigned RegW   = SbrObiCfg.DataWidth;
  localparam int unsigned SbrIdW = SbrObiCfg.IdWidth;
  localparam int unsigned AddrW  = MgrObiCfg.AddrWidth;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;

  localparam logic [2:0] OffSrc    = 3'd0;
  localparam logic [2:0] OffDst    = 3'd1;
  localparam logic [2:0] OffLen    = 3'd2;
  localparam logic [2:0] OffCtrl   = 3'd3;
  localparam logic [2:0] OffStatus = 3'd4;
  localparam logic [2:0] OffCount  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [AddrW-1:0]    src_q, src_d, dst_q, dst_d;
  logic [LenWidth-1:0] len_q, len_d, count_q, count_d, count_inc;
  logic [RegW-1:0]     buf_q, buf_d;
  logic                irq_en_q, irq_en_d, done_q, done_d, err_q, err_d;
  logic                sbr_rvalid_q, sbr_rvalid_d;
  logic [SbrIdW-1:0]   sbr_rid_q, sbr_rid_d;
  logic [RegW-1:0]     sbr_rdata_q, sbr_rdata_d;
  mgr_obi_req_t        mgr_req_q, mgr_req_d;
  logic                irq_q, irq_d;

  logic                busy, reg_wr, start;
  logic [2:0]          reg_idx;
  logic                unused_inputs;

  assign busy      = (state_q != IDLE);
  assign reg_wr    = sbr_obi_req_i.req & sbr_obi_req_i.a.we;
  assign reg_idx   = sbr_obi_req_i.a.addr[4:2];
  assign count_inc = count_q + LenWidth'(1);

  // Byte enables, unused address bits and the manager rid carry no meaning here.
  assign unused_inputs = ^{sbr_obi_req_i.a.be, sbr_obi_req_i.a.addr[31:5],
                           sbr_obi_req_i.a.addr[1:0], mgr_obi_rsp_i.r.rid};

  // Register port: combinational grant, registered response.
  always_comb begin
    sbr_obi_rsp_o          = '0;
    sbr_obi_rsp_o.gnt      = sbr_obi_req_i.req;
    sbr_obi_rsp_o.rvalid   = sbr_rvalid_q;
    sbr_obi_rsp_o.r.rdata  = sbr_rdata_q;
    sbr_obi_rsp_o.r.rid    = sbr_rid_q;
    sbr_obi_rsp_o.r.err    = 1'b0;
  end

  assign mgr_obi_req_o = mgr_req_q;
  assign irq_o         = irq_q;

  // Next-state: register file, copy FSM and the registered manager request.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    count_d      = count_q;
    buf_d        = buf_q;
    irq_en_d     = irq_en_q;
    done_d       = done_q;
    err_d        = err_q;
    start        = 1'b0;
    sbr_rvalid_d = sbr_obi_req_i.req;
    sbr_rid_d    = sbr_obi_req_i.a.aid;
    sbr_rdata_d  = '0;
    mgr_req_d    = '0;

    // Read data reflects the state in the grant cycle.
    if (sbr_obi_req_i.req && !sbr_obi_req_i.a.we) begin
      unique case (reg_idx)
        OffSrc:    sbr_rdata_d = RegW'(src_q);
        OffDst:    sbr_rdata_d = RegW'(dst_q);
        OffLen:    sbr_rdata_d = RegW'(len_q);
        OffCtrl:   sbr_rdata_d = RegW'({irq_en_q, 1'b0});
        OffStatus: sbr_rdata_d = RegW'({err_q, done_q, busy});
        OffCount:  sbr_rdata_d = RegW'(count_q);
        default:   sbr_rdata_d = '0;
      endcase
    end

    // Transfer parameters are frozen while busy; IRQ_EN and W1C stay open.
    if (reg_wr) begin
      unique case (reg_idx)
        OffSrc: if (!busy) src_d = AddrW'({sbr_obi_req_i.a.wdata[RegW-1:2], 2'b00});
        OffDst: if (!busy) dst_d = AddrW'({sbr_obi_req_i.a.wdata[RegW-1:2], 2'b00});
        OffLen: if (!busy) len_d = sbr_obi_req_i.a.wdata[LenWidth-1:0];
        OffCtrl: begin
          irq_en_d = sbr_obi_req_i.a.wdata[1];
          start    = sbr_obi_req_i.a.wdata[0] & ~busy;
        end
        OffStatus: begin
          done_d = done_q & ~sbr_obi_req_i.a.wdata[1];
          err_d  = err_q & ~sbr_obi_req_i.a.wdata[2];
        end
        default: ;
      endcase
    end

    // FSM updates come after the W1C so a same-cycle set wins.
    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
          err_d   = 1'b0;
          done_d  = (len_q == '0);
          if (len_q != '0) state_d = RD_REQ;
        end
      end
      RD_REQ:  if (mgr_obi_rsp_i.gnt) state_d = RD_WAIT;
      RD_WAIT: begin
        if (mgr_obi_rsp_i.rvalid) begin
          if (mgr_obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            buf_d   = mgr_obi_rsp_i.r.rdata;
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ:  if (mgr_obi_rsp_i.gnt) state_d = WR_WAIT;
      WR_WAIT: begin
        if (mgr_obi_rsp_i.rvalid) begin
          if (mgr_obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            count_d = count_inc;
            if (count_inc == len_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = RD_REQ;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Request for the next cycle; held stable while waiting for gnt.
    unique case (state_d)
      RD_REQ: begin
        mgr_req_d.req    = 1'b1;
        mgr_req_d.a.addr = src_q + AddrW'({count_d, 2'b00});
        mgr_req_d.a.be   = 4'hF;
      end
      WR_REQ: begin
        mgr_req_d.req     = 1'b1;
        mgr_req_d.a.we    = 1'b1;
        mgr_req_d.a.addr  = dst_q + AddrW'({count_d, 2'b00});
        mgr_req_d.a.wdata = buf_d;
        mgr_req_d.a.be    = 4'hF;
      end
      default: ;
    endcase

    irq_d = done_d & irq_en_d;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      count_q      <= '0;
      buf_q        <= '0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sbr_rvalid_q <= 1'b0;
      sbr_rid_q    <= '0;
      sbr_rdata_q  <= '0;
      mgr_req_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      count_q      <= count_d;
      buf_q        <= buf_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      err_q        <= err_d;
      sbr_rvalid_q <= sbr_rvalid_d;
      sbr_rid_q    <= sbr_rid_d;
      sbr_rdata_q  <= sbr_rdata_d;
      mgr_req_q    <= mgr_req_d;
      irq_q        <= irq_d;
    end
  end

endmodule

// File: tb/tb_user_obi_copy_engine.sv
// tb_user_obi_copy_engine: directed/randomized bench for the OBI copy engine.
// A behavioural memory answers the manager port (optional random gnt/rvalid
// delays, error injection) and logs every granted transaction; expected
// traffic and memory contents are derived from plain address arithmetic.
`timescale 1ns/1ps
module tb_user_obi_copy_engine;
  import user_obi_copy_engine_pkg::*;

  typedef struct {
    bit        we;
    bit [31:0] addr;
    bit [31:0] data;
  } txn_t;

  localparam bit [31:0] R_SRC = 32'h00, R_DST = 32'h04, R_LEN = 32'h08;
  localparam bit [31:0] R_CTRL = 32'h0C, R_STATUS = 32'h10, R_COUNT = 32'h14;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  obi_req_t sbr_req = '0;
  obi_rsp_t sbr_rsp;
  obi_req_t mgr_req;
  obi_rsp_t mgr_rsp = '0;
  logic     irq;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc_cnt  = 0;

  // Memory model state.
  bit [31:0] mem [bit [31:0]];
  txn_t      trace[$];
  bit [31:0] src_words[$];
  bit        bp_mode = 0, hold_wr = 0, stray = 0, err_en = 0;
  bit [31:0] err_addr = 0;
  bit        outstanding = 0, resp_driven = 0, gdly_set = 0, prev_wait = 0;
  bit        p_we = 0, p_err = 0;
  bit [31:0] p_addr = 0;
  int        gdly = 0, rdly = 0;
  obi_a_t    prev_a = '0;
  int        proto_viol = 0, req_cycles = 0;

  user_obi_copy_engine #(.LenWidth(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .sbr_obi_req_i(sbr_req),
    .sbr_obi_rsp_o(sbr_rsp),
    .mgr_obi_req_o(mgr_req),
    .mgr_obi_rsp_i(mgr_rsp),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Memory responder: decides gnt/rvalid at the falling edge for the next rising edge.
  always @(negedge clk) begin
    mgr_rsp = '0;
    if (!rst_n) begin
      outstanding = 0; resp_driven = 0; gdly_set = 0; prev_wait = 0;
    end else begin
      if (resp_driven) begin
        outstanding = 0;
        resp_driven = 0;
      end
      if (mgr_req.req) req_cycles++;
      if (mgr_req.req && outstanding) proto_viol++;
      if (prev_wait && (!mgr_req.req || mgr_req.a !== prev_a)) proto_viol++;
      if (stray) begin
        mgr_rsp.rvalid  = 1'b1;
        mgr_rsp.r.err   = 1'b1;
        mgr_rsp.r.rdata = 32'hDEAD_BEEF;
        stray = 0;
      end else if (outstanding) begin
        if (rdly == 0) begin
          mgr_rsp.rvalid  = 1'b1;
          mgr_rsp.r.err   = p_err;
          mgr_rsp.r.rdata = (!p_we && mem.exists(p_addr)) ? mem[p_addr] : 32'h0;
          resp_driven = 1;
        end else begin
          rdly--;
        end
      end
      if (mgr_req.req && !outstanding && !(hold_wr && mgr_req.a.we)) begin
        if (!gdly_set) begin
          gdly = bp_mode ? int'($urandom_range(0, 5)) : 0;
          gdly_set = 1;
        end
        if (gdly == 0) begin
          mgr_rsp.gnt = 1'b1;
          outstanding = 1;
          gdly_set    = 0;
          p_we   = mgr_req.a.we;
          p_addr = mgr_req.a.addr;
          p_err  = err_en && !mgr_req.a.we && (mgr_req.a.addr == err_addr);
          rdly   = bp_mode ? int'($urandom_range(0, 4)) : 0;
          if (p_we) mem[p_addr] = mgr_req.a.wdata;
          trace.push_back('{we: mgr_req.a.we, addr: mgr_req.a.addr, data: mgr_req.a.wdata});
        end else begin
          gdly--;
        end
      end
      prev_wait = mgr_req.req && !mgr_rsp.gnt;
      prev_a    = mgr_req.a;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One register access; called just after a falling edge, returns one cycle later.
  task automatic reg_access(input bit we, input bit [31:0] addr, input bit [31:0] wdata,
                            output bit [31:0] rdata);
    bit [3:0] id;
    id = 4'($urandom_range(0, 15));
    sbr_req.req     = 1'b1;
    sbr_req.a.we    = we;
    sbr_req.a.addr  = 32'h2000_0000 | addr;
    sbr_req.a.wdata = wdata;
    sbr_req.a.be    = 4'hF;
    sbr_req.a.aid   = id;
    #1;
    check("sbr_gnt", 32'(sbr_rsp.gnt), 32'd1);
    @(negedge clk);
    sbr_req = '0;
    check("sbr_rsp_valid_err_rid", 32'({sbr_rsp.rvalid, sbr_rsp.r.err, sbr_rsp.r.rid}),
          32'({1'b1, 1'b0, id}));
    rdata = sbr_rsp.r.rdata;
  endtask

  task automatic wr(input bit [31:0] addr, input bit [31:0] data);
    bit [31:0] unused_rd;
    reg_access(1'b1, addr, data, unused_rd);
  endtask

  task automatic rd_chk(input string tag, input bit [31:0] addr, input bit [31:0] exp);
    bit [31:0] v;
    reg_access(1'b0, addr, 32'h0, v);
    check(tag, v, exp);
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(irq), 32'd1);
  endtask

  // Fill the source with random words, program and start; returns the start-grant cycle.
  task automatic run_copy(input bit [31:0] src, input bit [31:0] dst, input int len,
                          output int start_cyc);
    src_words.delete();
    trace.delete();
    for (int k = 0; k < len; k++) begin
      bit [31:0] w;
      w = $urandom;
      src_words.push_back(w);
      mem[src + 32'(4 * k)] = w;
      if (mem.exists(dst + 32'(4 * k))) mem.delete(dst + 32'(4 * k));
    end
    wr(R_SRC, src);
    wr(R_DST, dst);
    wr(R_LEN, 32'(len));
    wr(R_CTRL, 32'h3);
    start_cyc = cyc_cnt;
  endtask

  // Expected traffic: R(src+4k), W(dst+4k, word k) for k < words, strictly alternating.
  task automatic check_copy(input string tag, input bit [31:0] src, input bit [31:0] dst,
                            input int words);
    for (int k = 0; k < words; k++) begin
      bit [31:0] sa, da;
      sa = src + 32'(4 * k);
      da = dst + 32'(4 * k);
      if (2 * k + 1 < trace.size()) begin
        check({tag, "_rd_addr"}, trace[2*k].addr, sa);
        check({tag, "_rd_we"}, 32'(trace[2*k].we), 32'd0);
        check({tag, "_wr_addr"}, trace[2*k+1].addr, da);
        check({tag, "_wr_we"}, 32'(trace[2*k+1].we), 32'd1);
      end
      check({tag, "_dst_word"}, mem.exists(da) ? mem[da] : 32'hBAD0_BAD0, src_words[k]);
    end
  endtask

  initial begin
    int t0, rq0;
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, rq0;
    bit [31:0] s, d;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_mgr_req", 32'(mgr_req.req), 32'd0);
    check("rst_mgr_a_zero", 32'(mgr_req.a != '0), 32'd0);
    check("rst_sbr_rvalid", 32'(sbr_rsp.rvalid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) rd_chk("rst_reg", 32'(4 * i), 32'h0);

    // Basic copy: 4 words, zero-wait memory, 16-cycle completion.
    s = 32'h1000_0000; d = 32'h1000_0100;
    run_copy(s, d, 4, t0);
    rd_chk("basic_busy_next_cycle", R_STATUS, 32'h1);
    wait_irq("basic_irq", 100);
    check("basic_done_latency", 32'(cyc_cnt - t0), 32'd16);
    check("basic_trace_len", 32'(trace.size()), 32'd8);
    check_copy("basic", s, d, 4);
    rd_chk("basic_count", R_COUNT, 32'd4);
    rd_chk("basic_status", R_STATUS, 32'h2);
    wr(R_STATUS, 32'h2);
    check("irq_falls_on_w1c", 32'(irq), 32'd0);

    // Register write masking.
    wr(R_SRC, 32'h0000_1003);
    rd_chk("src_align", R_SRC, 32'h0000_1000);
    wr(R_DST, 32'h0000_2002);
    rd_chk("dst_align", R_DST, 32'h0000_2000);

    // LEN=0: done immediately, no bus traffic.
    trace.delete();
    rq0 = req_cycles;
    wr(R_LEN, 32'h0);
    wr(R_CTRL, 32'h3);
    check("len0_irq_next_cycle", 32'(irq), 32'd1);
    rd_chk("len0_status", R_STATUS, 32'h2);
    repeat (5) @(negedge clk);
    check("len0_no_req", 32'(req_cycles - rq0), 32'd0);
    check("len0_no_txn", 32'(trace.size()), 32'd0);
    wr(R_STATUS, 32'h6);

    // Address wrap.
    s = 32'hFFFF_FFFC; d = 32'h3000_0000;
    run_copy(s, d, 2, t0);
    wait_irq("wrap_irq", 100);
    check("wrap_trace_len", 32'(trace.size()), 32'd4);
    check_copy("wrap", s, d, 2);
    if (trace.size() > 2) check("wrap_second_rd", trace[2].addr, 32'h0000_0000);
    wr(R_STATUS, 32'h6);

    // Read error on word 2 of 5.
    s = 32'h1000_0200; d = 32'h1000_0300;
    err_en = 1; err_addr = s + 32'd8;
    run_copy(s, d, 5, t0);
    wait_irq("err_irq", 100);
    rq0 = req_cycles;
    repeat (10) @(negedge clk);
    check("err_no_further_req", 32'(req_cycles - rq0), 32'd0);
    check("err_trace_len", 32'(trace.size()), 32'd5);
    check_copy("err", s, d, 2);
    if (trace.size() > 4) check("err_rd_addr", trace[4].addr, err_addr);
    rd_chk("err_status", R_STATUS, 32'h6);
    rd_chk("err_count", R_COUNT, 32'd2);
    wr(R_STATUS, 32'h6);
    rd_chk("err_status_cleared", R_STATUS, 32'h0);
    err_en = 0;

    // Backpressure: random gnt and rvalid delays.
    bp_mode = 1;
    for (int it = 0; it < 2; it++) begin
      s = 32'h1100_0000 + 32'($urandom_range(0, 255)) * 4;
      d = 32'h1200_0000 + 32'($urandom_range(0, 255)) * 4;
      run_copy(s, d, 8, t0);
      wait_irq("bp_irq", 1000);
      check("bp_trace_len", 32'(trace.size()), 32'd16);
      check_copy("bp", s, d, 8);
      rd_chk("bp_count", R_COUNT, 32'd8);
      rd_chk("bp_status", R_STATUS, 32'h2);
      check("bp_protocol", 32'(proto_viol), 32'd0);
      wr(R_STATUS, 32'h2);
    end
    bp_mode = 0;

    // Busy protection: parameter writes and re-START are ignored mid-transfer.
    s = 32'h1000_0400; d = 32'h1000_0500;
    if (mem.exists(32'h5000_0000)) mem.delete(32'h5000_0000);
    run_copy(s, d, 4, t0);
    wr(R_DST, 32'h5000_0000);
    wr(R_LEN, 32'd9);
    wr(R_SRC, 32'h6000_0000);
    wr(R_CTRL, 32'h3);
    rd_chk("busy_dst_kept", R_DST, d);
    rd_chk("busy_len_kept", R_LEN, 32'd4);
    rd_chk("busy_src_kept", R_SRC, s);
    wait_irq("busy_irq", 100);
    check("busy_done_latency", 32'(cyc_cnt - t0), 32'd16);
    check("busy_trace_len", 32'(trace.size()), 32'd8);
    check_copy("busy", s, d, 4);
    rd_chk("busy_count", R_COUNT, 32'd4);
    check("busy_no_stray_dst", 32'(mem.exists(32'h5000_0000)), 32'd0);
    wr(R_STATUS, 32'h2);
    check("busy_irq_falls", 32'(irq), 32'd0);

    // Async reset while the write request is waiting for grant.
    hold_wr = 1;
    run_copy(32'h1000_0600, 32'h1000_0700, 2, t0);
    begin
      int n;
      n = 0;
      while (!(mgr_req.req && mgr_req.a.we) && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("rst_reached_wr_req", 32'(mgr_req.req && mgr_req.a.we), 32'd1);
    check("rst_held_protocol", 32'(proto_viol), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_req_drop", 32'(mgr_req.req), 32'd0);
    check("rst_async_a_zero", 32'(mgr_req.a != '0), 32'd0);
    check("rst_async_irq", 32'(irq), 32'd0);
    hold_wr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1;
    repeat (3) @(negedge clk);
    rq0 = req_cycles;
    for (int i = 0; i < 7; i++) rd_chk("post_rst_reg", 32'(4 * i), 32'h0);
    check("post_rst_no_req", 32'(req_cycles - rq0), 32'd0);
    check("post_rst_irq", 32'(irq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
